mem_arbiter: RTL
================

# mem_arbiter

Arbiter and sequencer that shares one single-ported unified memory between the pipeline's instruction-fetch port (PC/IF stage) and data-memory port (EX/MEM stage). It grants one access at a time and times each access with a fixed-latency counter. It returns read data and a one-cycle valid pulse to the winning requester. It drives a stall line into the hazard unit so that PC, IFID and later stages hold while a request waits.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 2, memory access latency in cycles (legal range 1..15)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- flush  in  1  PC redirect (PCsrc); squashes any fetch in flight
- halt  in  1  no new fetch grants while high
- dm_re  in  1  data read request; held until dm_valid
- dm_we  in  1  data write request; held until dm_valid; dm_re and dm_we must not both be high
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid with dm_valid
- dm_valid  out  1  one-cycle data completion pulse, for both loads and stores
- stall  out  1  high when any request is pending and not completing this cycle
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- cnt_conflict  out  16  perf: cycles in IDLE with both ports requesting (see Configuration)
- cnt_stall  out  16  perf: cycles with stall high (see Configuration)

## Operation
- States: IDLE, IF_ACC, DM_ACC.
- IDLE:
  - If dm_re or dm_we is high: go to DM_ACC. Data has fixed priority, because it belongs to the older instruction.
  - Else if if_req is high and flush and halt are both low: go to IF_ACC.
  - Else stay in IDLE.
- On grant:
  - Register the address, write data and direction.
  - Load the latency counter with MEM_LAT-1.
- IF_ACC / DM_ACC:
  - Drive mem_en=1, mem_addr and mem_wdata from the registers.
  - Drive mem_we=1 only for a DM write.
  - Decrement the counter each cycle.
  - When the counter is 0: capture mem_rdata into the port's rdata register, pulse that port's valid for the next cycle, and return to IDLE.
- Flush:
  - flush high in any cycle of IF_ACC sets a drop flag.
  - The memory access still completes, but if_valid is suppressed and if_rdata is not updated.
  - The drop flag clears on return to IDLE.
  - flush has no effect on DM accesses.
- stall = (if_req & ~if_valid) | ((dm_re | dm_we) & ~dm_valid). This is combinational from registered state and inputs.
- The valid cycle doubles as the IDLE arbitration cycle, so back-to-back accesses are allowed.
- No request is lost:
  - A pending fetch waits in IDLE behind any number of consecutive DM requests.
  - Starvation is acceptable because DM requests stall the pipeline and so cannot recur indefinitely.

## Timing
- Reset values: state IDLE, counter 0, drop flag 0, and every output 0 (including rdata registers and counters).
- Reset asserted mid-access: abandon the access immediately and drop mem_en/mem_we asynchronously. A write in progress is undefined in memory.
- Request seen in IDLE at edge k:
  - mem_en is high for cycles k+1 .. k+MEM_LAT.
  - The valid pulse is in cycle k+MEM_LAT+1.
  - Latency from request to valid is MEM_LAT+1 cycles.
  - Peak throughput is one access per MEM_LAT+1 cycles.
- MEM_LAT=1: one access cycle, and the counter is loaded with 0.
- mem_addr and mem_wdata are stable for the whole access regardless of input changes.

## Configuration
- MEM_ARB_PERF_EN defined:
  - cnt_conflict increments in every IDLE cycle where both a DM request and if_req are high.
  - cnt_stall increments in every cycle with stall high.
  - Both counters saturate at 16'hFFFF and reset to 0.
- MEM_ARB_PERF_EN undefined: both ports exist, are tied to 0, and no counter flops are built.

## Structure
- Shared package mem_arb_pkg holds the state encoding (ST_IDLE=2'd0, ST_IF=2'd1, ST_DM=2'd2) and the counter width constant LAT_W=4.
- Sub-module mem_arb_lat_cnt: loadable down-counter with a zero flag, instantiated once.

## Test plan
- MEM_LAT=2, if_req with if_addr=16'h0010, mem_rdata=16'hB123 -> mem_en high for 2 cycles, if_valid pulses in the 3rd cycle with if_rdata=16'hB123, stall low in that cycle.
- if_req and dm_re raised at the same edge, dm_addr=16'h0040 -> DM is served first (dm_valid at +3), the fetch is granted in the dm_valid cycle, and if_valid arrives at +6.
- dm_we with dm_addr=16'h0022 and dm_wdata=16'h5A5A -> mem_we=1 for exactly MEM_LAT cycles, dm_valid pulses, and dm_rdata is unchanged.
- flush pulsed in the 1st cycle of IF_ACC -> no if_valid, FSM back in IDLE at +3, and the next fetch proceeds normally.
- rst_n dropped in the middle of DM_ACC -> all outputs 0 asynchronously; after release, a new request completes with normal latency.
- With MEM_ARB_PERF_EN defined, 3 simultaneous-request episodes -> cnt_conflict=3; with the macro undefined -> cnt_conflict stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IF   = 2'd1,
    ST_DM   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter timing one memory access; zero marks the final access cycle.
module mem_arb_lat_cnt
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [LAT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access (data has priority).
// Optional perf counters are built only when MEM_ARB_PERF_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              flush,
  input  logic              halt,
  input  logic              dm_re,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       cnt_conflict,
  output logic [15:0]       cnt_stall
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, if_rdata_q, dm_rdata_q;
  logic              we_q, drop_q, if_valid_q, dm_valid_q;
  logic              dm_pend, if_pend, grant_dm, grant_if, done, lat_zero;

  // A requester still holds its request during its valid cycle; mask it so the
  // valid cycle can arbitrate for the other port without re-granting.
  assign dm_pend = (dm_re | dm_we) & ~dm_valid_q;
  assign if_pend = if_req & ~if_valid_q;

  always_comb begin
    state_d  = state_q;
    grant_dm = 1'b0;
    grant_if = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (dm_pend) begin
          grant_dm = 1'b1;
          state_d  = ST_DM;
        end else if (if_pend && !flush && !halt) begin
          grant_if = 1'b1;
          state_d  = ST_IF;
        end
      end
      ST_IF, ST_DM: begin
        if (lat_zero) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mem_arb_lat_cnt u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (grant_dm | grant_if),
    .load_val (LAT_W'(MEM_LAT - 1)),
    .dec      (state_q != ST_IDLE),
    .zero     (lat_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      drop_q     <= 1'b0;
      if_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_rdata_q <= '0;
      dm_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if (grant_dm || grant_if) begin
        addr_q  <= grant_dm ? dm_addr : if_addr;
        wdata_q <= grant_dm ? dm_wdata : '0;
        we_q    <= grant_dm & dm_we;
      end
      if (state_q == ST_IF) begin
        if (done) begin
          drop_q <= 1'b0;
          // A flush in the final cycle squashes the fetch just like an earlier one.
          if (!(drop_q || flush)) begin
            if_valid_q <= 1'b1;
            if_rdata_q <= mem_rdata;
          end
        end else if (flush) begin
          drop_q <= 1'b1;
        end
      end
      if ((state_q == ST_DM) && done) begin
        dm_valid_q <= 1'b1;
        if (!we_q) begin
          dm_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = (state_q != ST_IDLE);
  assign mem_we    = (state_q == ST_DM) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_valid  = dm_valid_q;
  assign stall     = (if_req & ~if_valid_q) | ((dm_re | dm_we) & ~dm_valid_q);

`ifdef MEM_ARB_PERF_EN
  logic [15:0] cnt_conflict_q, cnt_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_conflict_q <= '0;
      cnt_stall_q    <= '0;
    end else begin
      if ((state_q == ST_IDLE) && dm_pend && if_pend && (cnt_conflict_q != 16'hFFFF)) begin
        cnt_conflict_q <= cnt_conflict_q + 16'd1;
      end
      if (stall && (cnt_stall_q != 16'hFFFF)) begin
        cnt_stall_q <= cnt_stall_q + 16'd1;
      end
    end
  end

  assign cnt_conflict = cnt_conflict_q;
  assign cnt_stall    = cnt_stall_q;
`else
  assign cnt_conflict = 16'h0000;
  assign cnt_stall    = 16'h0000;
`endif

endmodule
